// File: rtl/cdr_phase_picker.sv
// Oversampled (8x) clock/data recovery phase picker with vote-filtered phase tracking and lock detect.
// Define CDR_DIN_SYNC_EN to put a two-flop synchroniser on din (adds 2 clk of latency).
module cdr_phase_picker #(
  parameter int unsigned FILT_THRESH = 4,
  parameter int unsigned LOCK_CNT    = 16,
  parameter int unsigned RUN_LIMIT   = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] phase,
  input  logic       din,
  output logic       dout,
  output logic       dout_valid,
  output logic [2:0] sel_phase,
  output logic       locked,
  output logic       phase_err
);

  // state   | meaning
  // ACQUIRE | waiting for the first data edge to seed sel_phase
  // TRACK   | filtering edge votes, emitting recovered bits
  typedef enum logic {ACQUIRE, TRACK} state_t;

  localparam logic signed [4:0] ACC_HI   = 5'(FILT_THRESH);
  localparam logic signed [4:0] ACC_LO   = -ACC_HI;
  localparam logic [7:0]        LOCK_MAX = 8'(LOCK_CNT);
  localparam logic [7:0]        RUN_MAX  = 8'(RUN_LIMIT);

  state_t            state, state_nxt;
  logic signed [4:0] acc, acc_nxt, acc_step;
  logic [7:0]        lock_cnt, lock_nxt;
  logic [7:0]        run_cnt, run_nxt, run_inc;
  logic [2:0]        sel_nxt;
  logic              din_q, din_q_nxt;
  logic              dout_nxt, valid_nxt, locked_nxt, perr_nxt;

  logic       phase_ok;
  logic [2:0] p_raw, p_idx, exp_idx, err;
  logic       din_s, edge_hit;
  logic       vote_up, vote_dn, err_good, err_bad;

  assign phase_ok = (phase != 8'd0) && ((phase & (phase - 8'd1)) == 8'd0);

  always_comb begin
    p_raw = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (phase[i]) p_raw = 3'(i);
    end
  end

`ifdef CDR_DIN_SYNC_EN
  logic din_m, din_y;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      din_m <= 1'b0;
      din_y <= 1'b0;
    end else begin
      din_m <= din;
      din_y <= din_m;
    end
  end

  // The phase vector moved two positions while din crossed the synchroniser.
  assign din_s = din_y;
  assign p_idx = p_raw - 3'd2;
`else
  assign din_s = din;
  assign p_idx = p_raw;
`endif

  assign edge_hit = din_s ^ din_q;
  assign exp_idx  = sel_phase + 3'd4;
  assign err      = p_idx - exp_idx;
  assign vote_up  = err inside {3'd1, 3'd2, 3'd3};
  assign vote_dn  = err inside {3'd5, 3'd6, 3'd7};
  assign err_good = err inside {3'd0, 3'd1, 3'd7};
  assign err_bad  = err inside {3'd2, 3'd3, 3'd5, 3'd6};
  assign run_inc  = run_cnt + 8'd1;

  always_comb begin
    acc_step = acc;
    if (vote_up)      acc_step = acc + 5'sd1;
    else if (vote_dn) acc_step = acc - 5'sd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ACQUIRE;
      sel_phase  <= 3'd4;
      acc        <= '0;
      lock_cnt   <= '0;
      run_cnt    <= '0;
      din_q      <= 1'b0;
      dout       <= 1'b0;
      dout_valid <= 1'b0;
      locked     <= 1'b0;
      phase_err  <= 1'b0;
    end else begin
      state      <= state_nxt;
      sel_phase  <= sel_nxt;
      acc        <= acc_nxt;
      lock_cnt   <= lock_nxt;
      run_cnt    <= run_nxt;
      din_q      <= din_q_nxt;
      dout       <= dout_nxt;
      dout_valid <= valid_nxt;
      locked     <= locked_nxt;
      phase_err  <= perr_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    sel_nxt    = sel_phase;
    acc_nxt    = acc;
    lock_nxt   = lock_cnt;
    run_nxt    = run_cnt;
    din_q_nxt  = din_q;
    dout_nxt   = dout;
    valid_nxt  = 1'b0;
    locked_nxt = locked;
    perr_nxt   = phase_err;

    if (!phase_ok) begin
      perr_nxt = 1'b1;
    end else begin
      din_q_nxt = din_s;
      unique case (state)
        ACQUIRE: begin
          run_nxt = '0;
          if (edge_hit) begin
            sel_nxt   = p_idx + 3'd4;
            acc_nxt   = '0;
            lock_nxt  = '0;
            state_nxt = TRACK;
          end
        end
        TRACK: begin
          // Sample uses the registered sel_phase; filter updates land next cycle.
          if (p_idx == sel_phase) begin
            dout_nxt  = din_s;
            valid_nxt = 1'b1;
          end
          if (edge_hit) begin
            run_nxt = '0;
            if (acc_step == ACC_HI) begin
              sel_nxt = sel_phase + 3'd1;
              acc_nxt = '0;
            end else if (acc_step == ACC_LO) begin
              sel_nxt = sel_phase - 3'd1;
              acc_nxt = '0;
            end else begin
              acc_nxt = acc_step;
            end
            if (err_good)     lock_nxt = (lock_cnt == LOCK_MAX) ? lock_cnt : lock_cnt + 8'd1;
            else if (err_bad) lock_nxt = '0;
            locked_nxt = (lock_nxt == LOCK_MAX);
          end else if (p_idx == 3'd0) begin
            run_nxt = run_inc;
            if (run_inc == RUN_MAX) begin
              state_nxt  = ACQUIRE;
              locked_nxt = 1'b0;
              acc_nxt    = '0;
              run_nxt    = '0;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cdr_phase_picker.sv
// Randomised and directed bench for cdr_phase_picker against a per-cycle arithmetic reference model.
module tb_cdr_phase_picker;
  localparam int FT = 4;
  localparam int LC = 16;
  localparam int RL = 64;
`ifdef CDR_DIN_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] phase;
  logic       din;
  logic       dout, dout_valid, locked, phase_err;
  logic [2:0] sel_phase;

  cdr_phase_picker #(.FILT_THRESH(FT), .LOCK_CNT(LC), .RUN_LIMIT(RL)) dut (
    .clk(clk), .rst(rst), .phase(phase), .din(din),
    .dout(dout), .dout_valid(dout_valid), .sel_phase(sel_phase),
    .locked(locked), .phase_err(phase_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: integers, modular arithmetic, queue for the din delay.
  int m_sel, m_acc, m_lock, m_run;
  bit m_track, m_prev, m_dout, m_valid, m_locked, m_perr;
  bit dq[$];

  task automatic model_reset();
    m_sel = 4; m_acc = 0; m_lock = 0; m_run = 0;
    m_track = 0; m_prev = 0; m_dout = 0; m_valid = 0; m_locked = 0; m_perr = 0;
    dq = {};
    for (int i = 0; i < LAT; i++) dq.push_back(1'b0);
  endtask

  task automatic model_step(input logic [7:0] ph, input bit d);
    bit ds, hit;
    int p, err;
    if (LAT == 0) ds = d;
    else begin
      dq.push_back(d);
      ds = dq.pop_front();
    end
    m_valid = 0;
    if ($countones(ph) != 1) begin
      m_perr = 1;
      return;
    end
    p = ($clog2(ph) - LAT + 8) % 8;
    hit = (ds != m_prev);
    m_prev = ds;
    if (!m_track) begin
      if (hit) begin
        m_sel = (p + 4) % 8; m_acc = 0; m_lock = 0; m_run = 0; m_track = 1;
      end
      return;
    end
    if (p == m_sel) begin
      m_dout = ds;
      m_valid = 1;
    end
    if (hit) begin
      m_run = 0;
      err = ((p - m_sel - 4) % 8 + 16) % 8;
      if (err >= 4) err -= 8;
      if (err > 0) m_acc++;
      else if (err < 0 && err != -4) m_acc--;
      if (m_acc == FT) begin m_sel = (m_sel + 1) % 8; m_acc = 0; end
      else if (m_acc == -FT) begin m_sel = (m_sel + 7) % 8; m_acc = 0; end
      if (err >= -1 && err <= 1) m_lock = (m_lock < LC) ? m_lock + 1 : LC;
      else if (err != -4) m_lock = 0;
      m_locked = (m_lock == LC);
    end else if (p == 0) begin
      m_run++;
      if (m_run == RL) begin
        m_track = 0; m_locked = 0; m_acc = 0; m_run = 0;
      end
    end
  endtask

  task automatic check_outputs();
    check_val("dout_valid", dout_valid, m_valid);
    check_val("dout", dout, m_dout);
    check_val("sel_phase", sel_phase, m_sel);
    check_val("locked", locked, m_locked);
    check_val("phase_err", phase_err, m_perr);
  endtask

  int ph_idx = 0;
  bit cur = 0;

  task automatic tick(input logic [7:0] ph, input bit d);
    phase = ph;
    din = d;
    model_step(ph, d);
    @(negedge clk);
    check_outputs();
  endtask

  // mode 0: alternating bits, 1: random bits, 2: constant line
  task automatic send_uis(input int n, input int edge_p, input int mode, input bit jit);
    int ep;
    ep = edge_p;
    for (int k = 0; k < n * 8; k++) begin
      if (ph_idx == ep) begin
        if (mode == 0) cur = ~cur;
        else if (mode == 1) cur = 1'($urandom_range(0, 1));
        if (jit) ep = (edge_p + int'($urandom_range(0, 2)) + 7) % 8;
      end
      tick(8'd1 << ph_idx, cur);
      ph_idx = (ph_idx + 1) % 8;
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    model_reset();
    #1;
    check_outputs();
    repeat (2) @(negedge clk);
    check_outputs();
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0;
    phase = 8'h01;
    din = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check_outputs();
    rst = 1'b1;

    // Alternating data, transitions at p=2: acquire, then lock.
    cur = 0;
    send_uis(20, 2, 0, 0);
    check_val("acq_sel", sel_phase, 3'd6);
    check_val("lock_first", locked, 1'b1);

    // Edges drift late: four up votes per step, including the 7->0 wrap.
    send_uis(4, 3, 0, 0);
    check_val("step_up_7", sel_phase, 3'd7);
    send_uis(4, 4, 0, 0);
    check_val("wrap_to_0", sel_phase, 3'd0);

    // One bad edge drops lock; exactly LOCK_CNT good edges restore it.
    send_uis(20, 4, 0, 0);
    check_val("relocked", locked, 1'b1);
    send_uis(1, 7, 0, 0);
    check_val("bad_edge_unlock", locked, 1'b0);
    check_val("bad_edge_sel", sel_phase, 3'd0);
    send_uis(15, 4, 0, 0);
    check_val("lock_minus1", locked, 1'b0);
    send_uis(1, 4, 0, 0);
    check_val("lock_at_cnt", locked, 1'b1);

    // Quiet line: one UI short of the run limit still tracks, then falls back.
    send_uis(63, 0, 2, 0);
    check_val("run_below_limit", locked, 1'b1);
    send_uis(1, 0, 2, 0);
    check_val("run_limit_unlock", locked, 1'b0);
    send_uis(3, 0, 2, 0);
    send_uis(1, 0, 0, 0);
    check_val("reacq_sel", sel_phase, 3'd4);

    // Invalid phase vector is sticky.
    tick(8'b0000_0011, cur);
    ph_idx = (ph_idx + 1) % 8;
    check_val("perr_set", phase_err, 1'b1);
    send_uis(4, 0, 0, 0);
    check_val("perr_sticky", phase_err, 1'b1);

    do_reset();
    check_val("perr_clr", phase_err, 1'b0);
    check_val("rst_sel", sel_phase, 3'd4);

    // Randomised jitter, data patterns, glitches and quiet stretches.
    for (int blk = 0; blk < 60; blk++) begin
      int sel;
      sel = int'($urandom_range(0, 19));
      if (sel == 0) begin
        tick(($urandom_range(0, 1) == 0) ? 8'h00 : 8'hA4, cur);
        ph_idx = (ph_idx + 1) % 8;
      end else if (sel == 1) begin
        send_uis(int'($urandom_range(60, 70)), 0, 2, 0);
      end else if (sel == 2) begin
        do_reset();
      end else begin
        send_uis(int'($urandom_range(2, 24)), int'($urandom_range(0, 7)),
                 int'($urandom_range(0, 1)), bit'($urandom_range(0, 1)));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
